// File: rtl/data_mem.sv
// Byte-wide single-port data memory with combinational read and clocked write.
// Optional feature: define DATA_MEM_RESET_CLEAR_EN to clear every location on reset.
module data_mem #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic [A-1:0] DataAddress,
  input  logic         ReadMem,
  input  logic         WriteMem,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] DataOut
);

  localparam int Depth = 1 << A;

  logic [W-1:0] mem [Depth];

  // Reset outranks the store; an X on WriteMem takes the else path, so no write occurs.
  always_ff @(posedge CLK) begin
    if (reset) begin
`ifdef DATA_MEM_RESET_CLEAR_EN
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
`endif
    end else if (WriteMem) begin
      mem[DataAddress] <= DataIn;
    end
  end

  // Unregistered read port, forced to zero whenever the load is not enabled.
  assign DataOut = ReadMem ? mem[DataAddress] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboarded bench for data_mem: directed cases plus randomized traffic
// against an array model of the memory.
module tb_data_mem;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  data_mem #(.W(8), .A(8)) dut (
    .CLK(CLK), .reset(reset), .DataAddress(DataAddress), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] addr;
    string      name;
  } item_t;

  item_t      sbq[$];
  logic [7:0] model [256];
  int         nChecks = 0;
  int         nFails  = 0;

  // Monitor: the DUT output is judged mid-cycle, before the edge commits anything.
  always @(negedge CLK) begin
    if (sbq.size() > 0) begin
      item_t it;
      it = sbq.pop_front();
      nChecks++;
      if (DataOut !== it.exp) begin
        nFails++;
        $display("FAIL %s addr=0x%02h got=0x%02h expected=0x%02h", it.name, it.addr, DataOut, it.exp);
      end
    end
  end

  // One processor cycle: drive, predict the combinational output, then apply the edge to the model.
  task automatic step(input logic [7:0] addr, input logic rd, input logic wr,
                      input logic [7:0] din, input logic rst, input string name);
    item_t it;
    reset       = rst;
    DataAddress = addr;
    ReadMem     = rd;
    WriteMem    = wr;
    DataIn      = din;
    it.exp  = rd ? model[addr] : 8'h00;
    it.addr = addr;
    it.name = name;
    sbq.push_back(it);
    @(posedge CLK);
    if (rst) begin
`ifdef DATA_MEM_RESET_CLEAR_EN
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
`endif
    end else if (wr) begin
      model[addr] = din;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0; DataAddress = 8'h00; ReadMem = 1'b0; WriteMem = 1'b0; DataIn = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    @(posedge CLK);
    #1;

    // Reset pulse with ReadMem low: output must be zero regardless of contents.
    step(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, "reset_rd0");
`ifndef DATA_MEM_RESET_CLEAR_EN
    // Contents survive reset in this build, so establish known zeros by writing them.
    for (int i = 0; i < 256; i++) step(8'(i), 1'b0, 1'b1, 8'h00, 1'b0, "init_rd0");
`endif
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "post_reset_00");
    step(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, "post_reset_ff");

    step(8'h0F, 1'b0, 1'b1, 8'h03, 1'b0, "wr_0f");
    step(8'h20, 1'b0, 1'b1, 8'h07, 1'b0, "wr_20");
    step(8'h20, 1'b1, 1'b0, 8'h00, 1'b0, "rd_20");
    step(8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, "rd_0f");
    step(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rd_00_untouched");
    step(8'h20, 1'b0, 1'b0, 8'h00, 1'b0, "rd_disabled_20");
    step(8'h0F, 1'b0, 1'b0, 8'h00, 1'b0, "rd_disabled_0f");

    for (int k = 0; k < 4; k++) step(8'h20, 1'b1, 1'b0, 8'h55, 1'b0, "no_write_hold_20");
    step(8'h20, 1'b1, 1'b0, 8'h00, 1'b0, "hold_20_after");

    // Store coinciding with reset is dropped; prior contents survive unless clearing is built in.
    step(8'h10, 1'b0, 1'b1, 8'h5A, 1'b0, "wr_10_prior");
    step(8'h10, 1'b1, 1'b1, 8'hAA, 1'b1, "wr_during_reset");
    step(8'h10, 1'b1, 1'b0, 8'h00, 1'b0, "rd_10_after_reset");
    step(8'h20, 1'b1, 1'b0, 8'h00, 1'b0, "rd_20_after_reset");

    // Read-during-write shows old data before the edge and new data after it.
    step(8'hFF, 1'b1, 1'b1, 8'h9C, 1'b0, "rdwr_ff_before");
    step(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, "rdwr_ff_after");

    for (int n = 0; n < 600; n++) begin
      logic [7:0] a;
      logic       r, w, rs;
      a  = 8'($urandom_range(0, 255));
      if (n % 3 == 0) a = {4'h3, a[3:0]};
      r  = 1'($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 49) == 0);
      step(a, r, w, 8'($urandom), rs, "random");
    end

    begin
      int waitCycles = 0;
      while (sbq.size() > 0 && waitCycles < 10) begin
        @(posedge CLK);
        waitCycles++;
      end
      if (sbq.size() > 0) begin
        nChecks++;
        nFails++;
        $display("FAIL drain pending=%0d required=0", sbq.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Single-port, byte-wide data memory for the single-cycle processor's load/store path: 256 locations of 8 bits, addressed by one shared 8-bit pointer. Writes commit on the rising clock edge when the store enable is high. Reads are combinational (same-cycle), so a load completes within one processor cycle. An optional synchronous reset clears the whole array.

## Interface
Parameters:
- W — 8 — data width in bits.
- A — 8 — address width in bits; depth is 2^A = 256 locations.

Ports:
- CLK  input  1  — sole clock; all state updates on its rising edge.
- reset  input  1  — synchronous, active-high; see Configuration.
- DataAddress  input  A  — pointer for both read and write.
- ReadMem  input  1  — read enable; gates DataOut.
- WriteMem  input  1  — store enable; required for any write.
- DataIn  input  W  — write data.
- DataOut  output  W  — read data.

## Operation
- Storage: array mem[0..255] of W bits, one location per DataAddress value; no address wrap or aliasing (full 8-bit decode).
- Write: at a rising CLK with WriteMem=1 and reset=0, mem[DataAddress] <= DataIn. With WriteMem=0, no location changes.
- Read: DataOut = mem[DataAddress] when ReadMem=1; DataOut = 0 when ReadMem=0.
- ReadMem and WriteMem are independent. Both high is legal: DataOut shows the pre-write contents until the edge, then the new value.
- Reset: at a rising CLK with reset=1, the clear action (if compiled in) applies and any write that cycle is suppressed. Reset has priority over WriteMem.
- DataOut has no register, so it has no reset value of its own. While reset=1 and ReadMem=0, DataOut=0.
- X on WriteMem must not corrupt memory in simulation; treat non-1 as no write.

## Timing
- Write latency: data visible at DataOut (ReadMem=1, same address) immediately after the capturing rising edge, i.e. 0 cycles after commit.
- Read latency: combinational. DataOut follows DataAddress/ReadMem changes within the same cycle, with no clock required.
- Reset: takes effect on the first rising edge with reset=1. All locations are cleared after that single edge; no multi-cycle clear sequence.
- Reset asserted mid-sequence: the pending write at that edge is dropped. Operation resumes on the first edge with reset=0.
- No handshake and no stall; every cycle accepts one read and/or one write.

## Configuration
- Macro DATA_MEM_RESET_CLEAR_EN.
- Defined: reset=1 at a rising edge sets all 256 locations to 0.
- Not defined:
  - reset only suppresses writes; memory contents are preserved across reset.
  - Power-up contents are undefined (X in simulation).

## Test plan
- Reset pulse (one edge, macro defined), then ReadMem=1 at DataAddress 0x00 -> DataOut=0x00. Repeat at 0xFF -> 0x00.
- Write 0x03 to 0x0F, then write 0x07 to 0x20 (WriteMem=1 for one edge each). Then ReadMem=1 at 0x20 -> 0x07 and at 0x0F -> 0x03. Address 0x00 stays 0x00.
- ReadMem=0 at any address after those writes -> DataOut=0x00.
- WriteMem=0 with DataIn=0x55 at 0x20 over several edges -> 0x20 still reads 0x07.
- WriteMem=1 together with reset=1 at 0x10, DataIn=0xAA -> 0x10 reads 0x00 afterward. Without the macro, an earlier value at 0x10 is preserved.
- ReadMem=1 and WriteMem=1 at 0xFF, DataIn=0x9C, prior value 0x00 -> DataOut=0x00 before the edge, 0x9C after it.
